// File: rtl/vlan_rr_sched.sv
// Round-robin scheduler sharing one VLAN lookup port among several requesters.
// Each requester has a private FIFO; issues are spaced by a SEND/WAIT gap.
module vlan_rr_sched #(
  parameter int C_NUM_REQ      = 4,
  parameter int C_VLANID_WIDTH = 12,
  parameter int C_FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [C_NUM_REQ*C_VLANID_WIDTH-1:0]  req_vlan_in,
  input  logic [C_NUM_REQ-1:0]                 req_vlan_valid_in,
  output logic [C_NUM_REQ-1:0]                 req_vlan_ready_out,
  output logic [C_VLANID_WIDTH-1:0]            act_vlan_out,
  output logic                                 act_vlan_valid_out,
  input  logic                                 act_vlan_ready_in,
  output logic [$clog2(C_NUM_REQ)-1:0]         grant_id_out,
  output logic [31:0]                          issue_cnt_out
);

  localparam int W  = C_VLANID_WIDTH;
  localparam int GW = $clog2(C_NUM_REQ);
  localparam int PW = $clog2(C_FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_mem  [C_NUM_REQ][C_FIFO_DEPTH];
  logic [PW-1:0]  r_wptr [C_NUM_REQ];
  logic [PW-1:0]  r_rptr [C_NUM_REQ];
  logic [CW-1:0]  r_occ  [C_NUM_REQ];

  logic [W-1:0]   r_act_vlan;
  logic           r_act_valid;
  logic [GW-1:0]  r_grant;
  logic [GW-1:0]  r_last;
  logic [31:0]    r_cnt;

  logic [C_NUM_REQ-1:0] w_push;
  logic [C_NUM_REQ-1:0] w_pop;
  logic [C_NUM_REQ-1:0] w_nempty;
  logic [C_NUM_REQ-1:0] w_ready;
  logic [GW-1:0]        w_win;
  logic [GW-1:0]        w_idx;
  logic                 w_found;
  logic                 w_issue;
  logic [W-1:0]         w_head;

  always_comb begin
    for (int i = 0; i < C_NUM_REQ; i++) begin
      w_ready[i]  = r_occ[i] != CW'(C_FIFO_DEPTH);
      w_nempty[i] = r_occ[i] != '0;
      w_push[i]   = req_vlan_valid_in[i] && w_ready[i];
      w_pop[i]    = w_issue && (w_win == GW'(i));
    end
  end

  // Search starts just past the last grant; GW-bit add wraps modulo C_NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      w_idx = r_last + GW'(k);
      if (!w_found && w_nempty[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_issue = (r_state == S_IDLE) && w_found && act_vlan_ready_in;
  assign w_head  = r_mem[w_win][r_rptr[w_win]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= req_vlan_in[(i+1)*W-1 -: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_NUM_REQ; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_occ[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < C_NUM_REQ; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
        if (w_push[i] && !w_pop[i]) begin
          r_occ[i] <= r_occ[i] + 1'b1;
        end else if (!w_push[i] && w_pop[i]) begin
          r_occ[i] <= r_occ[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_act_vlan  <= '0;
      r_act_valid <= 1'b0;
      r_grant     <= '0;
      r_last      <= GW'(C_NUM_REQ - 1);
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_act_vlan  <= w_head;
            r_grant     <= w_win;
            r_last      <= w_win;
            r_act_valid <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          r_act_valid <= 1'b0;
          r_cnt       <= r_cnt + 32'd1;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_act_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_vlan_ready_out = w_ready;
  assign act_vlan_out       = r_act_vlan;
  assign act_vlan_valid_out = r_act_valid;
  assign grant_id_out       = r_grant;
  assign issue_cnt_out      = r_cnt;

endmodule

// File: tb/tb_vlan_rr_sched.sv
// Directed bench for vlan_rr_sched: issue expectations are queued by the
// stimulus and popped by a monitor whenever the scheduler presents a valid.
module tb_vlan_rr_sched;

  localparam int NR = 4;
  localparam int VW = 12;

  typedef struct packed {
    logic [1:0]  g;
    logic [11:0] v;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NR*VW-1:0] req_data;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [VW-1:0]    act_vlan;
  logic             act_valid;
  logic             act_rdy;
  logic [1:0]       grant;
  logic [31:0]      cnt;

  logic eng_en;
  logic eng_busy;
  bit   gap_chk;
  int   cyc;
  int   errors;
  int   checks;
  int   exp_cnt;
  int   last_v;
  exp_t sb_q[$];
  exp_t e;

  vlan_rr_sched #(
    .C_NUM_REQ(NR),
    .C_VLANID_WIDTH(VW),
    .C_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_vlan_in(req_data),
    .req_vlan_valid_in(req_valid),
    .req_vlan_ready_out(req_ready),
    .act_vlan_out(act_vlan),
    .act_vlan_valid_out(act_valid),
    .act_vlan_ready_in(act_rdy),
    .grant_id_out(grant),
    .issue_cnt_out(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Downstream engine model: ready drops for one cycle after it sees a valid.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) eng_busy <= 1'b0;
    else        eng_busy <= act_valid;
  end
  assign act_rdy = eng_en & ~eng_busy;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      exp_cnt = 0;
      last_v  = -1;
    end else begin
      if (!gap_chk) last_v = -1;
      if (act_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got grant=%0d vlan=0x%03h, required no issue",
                   grant, act_vlan);
        end else begin
          e = sb_q.pop_front();
          chk("issue_vlan", 32'(act_vlan), 32'(e.v));
          chk("issue_grant", 32'(grant), 32'(e.g));
          chk("issue_cnt", cnt, 32'(exp_cnt));
          if (gap_chk && last_v >= 0) chk("issue_gap", 32'(cyc - last_v), 32'd3);
        end
        exp_cnt++;
        last_v = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int r, input logic [11:0] v);
    req_valid[r]         = 1'b1;
    req_data[r*VW +: VW] = v;
  endtask

  task automatic clr();
    req_valid = '0;
  endtask

  task automatic expect_issue(input int r, input logic [11:0] v);
    exp_t x;
    x.g = 2'(r);
    x.v = v;
    sb_q.push_back(x);
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
    repeat (6) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int vcount;
    int n;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    eng_en    = 1'b1;
    gap_chk   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tick();
    tick();
    chk("rst_vlan", 32'(act_vlan), 32'd0);
    chk("rst_valid", 32'(act_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'hF);
    rst_n = 1'b1;
    tick();

    // Single requester latency
    drv(2, 12'h0A5);
    expect_issue(2, 12'h0A5);
    tick();
    clr();
    chk("t1_c1_valid", 32'(act_valid), 32'd0);
    tick();
    chk("t1_c2_valid", 32'(act_valid), 32'd1);
    chk("t1_c2_grant", 32'(grant), 32'd2);
    tick();
    chk("t1_c3_cnt", cnt, 32'd1);
    chk("t1_c3_hold", 32'(act_vlan), 32'h0A5);
    drain("t1_drain", 20);

    // All four at once
    do_reset();
    gap_chk = 1'b1;
    for (int i = 0; i < NR; i++) begin
      drv(i, 12'(12'h010 + 12'h111 * i));
      expect_issue(i, 12'(12'h010 + 12'h111 * i));
    end
    tick();
    clr();
    drain("t2_drain", 40);
    gap_chk = 1'b0;

    // Alternation between requesters 1 and 3
    do_reset();
    gap_chk = 1'b1;
    drv(1, 12'h1A1);
    drv(3, 12'h3B1);
    tick();
    clr();
    drv(1, 12'h1A2);
    drv(3, 12'h3B2);
    tick();
    clr();
    expect_issue(1, 12'h1A1);
    expect_issue(3, 12'h3B1);
    expect_issue(1, 12'h1A2);
    expect_issue(3, 12'h3B2);
    drain("t3_drain", 40);
    gap_chk = 1'b0;

    // Full FIFO, refused push, then pointer wrap
    do_reset();
    eng_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_ready_before_push", 32'(req_ready[0]), 32'd1);
      drv(0, 12'(12'h101 + i));
      expect_issue(0, 12'(12'h101 + i));
      tick();
    end
    chk("t4_full_ready", 32'(req_ready[0]), 32'd0);
    drv(0, 12'h105);
    tick();
    clr();
    chk("t4_still_full", 32'(req_ready[0]), 32'd0);
    chk("t4_no_valid_blocked", 32'(act_valid), 32'd0);
    eng_en  = 1'b1;
    gap_chk = 1'b1;
    drain("t4_drain", 40);
    gap_chk = 1'b0;
    tick();
    gap_chk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (!req_ready[0] && n < 20) begin
        tick();
        n++;
      end
      chk("t4_wrap_ready_wait", 32'(n < 20), 32'd1);
      drv(0, 12'(12'h201 + i));
      expect_issue(0, 12'(12'h201 + i));
      tick();
      clr();
    end
    drain("t4_wrap_drain", 60);
    gap_chk = 1'b0;

    // Ready held low for 10 cycles
    do_reset();
    eng_en = 1'b0;
    drv(1, 12'h3C3);
    expect_issue(1, 12'h3C3);
    tick();
    clr();
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (act_valid) vcount++;
      tick();
    end
    chk("t5_no_valid_window", 32'(vcount), 32'd0);
    eng_en = 1'b1;
    tick();
    chk("t5_valid_after_ready", 32'(act_valid), 32'd1);
    drain("t5_drain", 20);

    // Asynchronous reset during SEND
    do_reset();
    drv(0, 12'h111);
    drv(1, 12'h222);
    drv(2, 12'h333);
    expect_issue(0, 12'h111);
    tick();
    clr();
    tick();
    chk("t6_in_send", 32'(act_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", 32'(act_valid), 32'd0);
    chk("t6_cnt_clear", cnt, 32'd0);
    chk("t6_vlan_clear", 32'(act_vlan), 32'd0);
    chk("t6_ready_all", 32'(req_ready), 32'hF);
    tick();
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (act_valid) vcount++;
    end
    chk("t6_no_issue_after_rst", 32'(vcount), 32'd0);
    chk("t6_cnt_after", cnt, 32'd0);
    chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vlan_rr_sched.md
# vlan_rr_sched

Round-robin scheduler that shares the action engine's single VLAN lookup port between several requesters (parser lanes or test injectors). Each requester pushes VLAN IDs into a private FIFO. The scheduler issues one VLAN at a time to the action engine. It respects that port's one-cycle-busy handshake, and it enforces a fixed gap after every issue so page-table reads never overlap.

## Interface
- C_NUM_REQ, 4: number of requesters; a power of 2, from 2 to 8.
- C_VLANID_WIDTH, 12: VLAN ID width.
- C_FIFO_DEPTH, 4: per-requester FIFO depth; a power of 2, at least 2.
- clk  input  1  single clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- req_vlan_in  input  C_NUM_REQ*C_VLANID_WIDTH  requester i occupies bits [(i+1)*W-1 -: W].
- req_vlan_valid_in  input  C_NUM_REQ  per-requester valid.
- req_vlan_ready_out  output  C_NUM_REQ  per-requester ready, equal to the FIFO being not full.
- act_vlan_out  output  C_VLANID_WIDTH  VLAN ID to the action engine; registered.
- act_vlan_valid_out  output  1  one-cycle issue pulse; registered.
- act_vlan_ready_in  input  1  action engine ready; drops for one cycle after it samples a valid.
- grant_id_out  output  clog2(C_NUM_REQ)  requester index of the current or last issue.
- issue_cnt_out  output  32  count of issues; wraps modulo 2^32.

## Operation
- Per-requester FIFO:
  - Push when req_vlan_valid_in[i] && req_vlan_ready_out[i].
  - Occupancy counter is clog2(DEPTH)+1 bits.
  - Read and write pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - A push to a full FIFO cannot occur, because ready is low.
- Arbitration:
  - Eligible set: all requesters with occupancy > 0.
  - Search order starts at last_grant+1 and wraps modulo C_NUM_REQ.
  - last_grant updates only on an issue.
  - Reset value of last_grant is C_NUM_REQ-1, so requester 0 wins first.
- States:
  - IDLE: if any FIFO is non-empty and act_vlan_ready_in=1, pop the FIFO head of the winner. Load act_vlan_out and grant_id_out, set act_vlan_valid_out, go to SEND. Otherwise stay in IDLE.
  - SEND: act_vlan_valid_out=1 for exactly this cycle; increment issue_cnt_out; go to WAIT unconditionally.
  - WAIT: valid=0; one mandatory gap cycle; go to IDLE.
- act_vlan_out holds the last issued value outside SEND.
- There is no backpressure on SEND. The downstream port must accept any valid it sees, and it does so whenever it is IDLE.
- Reset values: act_vlan_out=0, act_vlan_valid_out=0, grant_id_out=0, issue_cnt_out=0, req_vlan_ready_out all 1, all FIFOs empty, state IDLE.
- Reset mid-operation: buffered entries are discarded and outputs return to reset values immediately. A pulse that is in flight is truncated.

## Timing
- Push at edge t: the entry is visible to arbitration in cycle t+1.
- Decision in IDLE at cycle t: act_vlan_valid_out is high in cycle t+1.
- Minimum latency from push to valid: 2 cycles, when the FIFO was empty and the scheduler was idle.
- Issue spacing: at least 3 cycles (SEND, WAIT, IDLE). The scheduler also waits in IDLE while act_vlan_ready_in=0. With a downstream that drops ready for one cycle, spacing is exactly 3 cycles.
- req_vlan_ready_out is derived from registered occupancy.
  - It deasserts the cycle after the push that fills the FIFO.
  - It reasserts the cycle after the pop that frees a slot.
- Full, empty and wrap-around:
  - DEPTH consecutive pushes with no pop fill the FIFO.
  - The next push is refused.
  - After the pointers wrap, FIFO order is preserved.

## Test plan
- Single requester: push 0x0A5 into requester 2 at cycle 0 with the scheduler idle and ready=1. Required: valid high at cycle 2 with act_vlan_out=0x0A5, grant_id_out=2, issue_cnt_out=1 at cycle 3.
- All 4 requesters push one entry at the same time. Required: issue order 0,1,2,3, with valids exactly 3 cycles apart.
- Requesters 1 and 3 each push 2 entries. Required: issue order 1,3,1,3, alternating rather than draining one FIFO first.
- Push 5 entries back-to-back into requester 0 (DEPTH=4) with act_vlan_ready_in held 0. Required: ready_out[0] drops after the 4th push and the 5th push is refused. On releasing ready, exactly the first 4 values issue, in order. Then push 6 more values through to confirm pointer wrap keeps FIFO order.
- Hold act_vlan_ready_in=0 for 10 cycles with data pending. Required: no valid during that window; valid appears 1 cycle after ready rises.
- Assert rst_n=0 asynchronously during SEND with 2 entries buffered. Required: valid falls within the same cycle, and the FIFOs and counter clear. After release, no issue occurs without new pushes.
